uart_autoparity_rx: RTL and testbench
=====================================

Name: uart_autoparity_rx

Overview:
- 16x-oversampling UART receiver, directly downstream of the autobaud/autoparity detector.
- Consumes the detector's divisor, parity mode and done pulse. Generates its own sample tick and receives 8-bit frames with none, odd or even parity.
- Reports each byte with parity and framing status to the application/FIFO stage.

Parameters:
- DVSR_W, 12, width of the baud divisor input.
- DBIT, 8, data bits per frame.
- SB_TICK, 16, oversample ticks per bit (stop-bit length).

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- rx  in  1  serial line, asynchronous, idle high
- baud_dvsr  in  DVSR_W  clock cycles per oversample tick
- parity_mode  in  2  0 none, 1 odd, 2 even, 3 treated as none
- cfg_load  in  1  one-cycle pulse (detector done_tick): capture baud_dvsr and parity_mode
- s_tick  out  1  oversample tick, one clk wide
- dout  out  8  received byte
- rx_done_tick  out  1  one-cycle pulse, byte and flags valid
- parity_err  out  1  parity mismatch on the last frame
- frame_err  out  1  stop bit sampled 0 on the last frame
- cfg_ok  out  1  a configuration has been loaded

Behaviour:
- Reset values:
  - all outputs 0.
  - dvsr_reg=0, mode_reg=0, cfg_ok=0, state=IDLE, s=0, n=0.
  - rx synchronizer flops = 1.
- rx passes through a 2-flop synchronizer. All FSM references to rx mean the synchronized value, which lags the pin by 2 cycles.
- Config capture:
  - cfg_load while state==IDLE: latch baud_dvsr/parity_mode next edge, set cfg_ok=1.
  - cfg_load while busy: set pending flag and hold values; apply on the first IDLE cycle.
  - A newer cfg_load overwrites the pending values.
- Tick generator:
  - Counter runs 0..dvsr_reg-1; s_tick=1 in the cycle counter==dvsr_reg-1, then the counter wraps to 0.
  - dvsr_reg==0 or 1: dvsr 0 gives no ticks; dvsr 1 gives a tick every cycle.
  - Counter resets to 0 whenever dvsr_reg is updated.
- FSM. All s/n updates occur only on s_tick cycles, except the IDLE exit.
  - IDLE: if cfg_ok && rx==0, go to START with s=0. rx is ignored while cfg_ok==0.
  - START:
    - On tick with s==7: if rx==0, go to DATA with s=0, n=0. If rx==1 (glitch), return to IDLE with no pulse.
    - Otherwise s++.
  - DATA:
    - On tick with s==15: shift rx into b (LSB first), s=0.
    - If n==DBIT-1, go to PAR when mode_reg is odd or even, else to STOP. Otherwise n++.
    - Otherwise s++.
  - PAR:
    - On tick with s==15: latch p=rx, s=0, go to STOP.
    - Expected bit: even = XOR of the 8 data bits; odd = its inverse.
  - STOP: on tick with s==SB_TICK-1, sample rx and go to IDLE. In the next cycle:
    - rx_done_tick=1 for one cycle.
    - dout=b.
    - frame_err = ~sampled stop bit.
    - parity_err = (p != expected) in odd/even mode, 0 in none mode.
- Latency: rx_done_tick is asserted exactly one clk after the stop-sample tick.
- dout, parity_err and frame_err hold their values until the next rx_done_tick.
- A frame with frame_err=1 still pulses rx_done_tick. IDLE then needs rx==0 to restart, so a break condition (rx held low) restarts immediately. This is accepted.
- Reset mid-frame: asynchronous return to reset values. cfg_ok=0, so the receiver stays idle until the next cfg_load.
- Width rules: s is 4 bits, n is 3 bits, the tick counter is DVSR_W bits, compared against dvsr_reg-1 in DVSR_W bits.

Decomposition:
- Package uart_pkg holds:
  - PAR_NONE=2'd0, PAR_ODD=2'd1, PAR_EVEN=2'd2
  - state encoding IDLE/START/DATA/PAR/STOP (3 bits)
  - OVERSAMPLE=16
- The detector uses the same parity constants.
- Sub-module uart_baud_tick: clk, reset_n, dvsr, load → s_tick. It is the mod-dvsr counter described above.
- The synchronizer, config latch and FSM stay in the top module.

Test Plan:
- Config: clk 50 MHz, cfg_load with baud_dvsr=27, parity_mode=0, then send 0x55 8N1 at 115200 → one rx_done_tick, dout=0x55, parity_err=0, frame_err=0; s_tick period 27 clk.
- Even parity: mode=2, send 0x78 with parity bit 0 → dout=0x78, parity_err=0. Repeat with parity bit 1 → parity_err=1, dout still 0x78.
- Odd parity: mode=1, send 0x31 (3 ones) with parity bit 0 → parity_err=0. Send 0x33 with parity bit 0 → parity_err=1.
- Framing: mode=0, send 0xA5 with stop bit driven 0 → rx_done_tick, dout=0xA5, frame_err=1. Next clean 0x0F frame → frame_err=0.
- Glitch and unconfigured operation:
  - rx low for 3 ticks then high → no rx_done_tick, FSM back in IDLE.
  - Before any cfg_load, a full frame → no pulse, cfg_ok=0.
- Config timing:
  - cfg_load with dvsr=54 during DATA of a dvsr=27 frame → current frame completes at 27, next frame received correctly at 54.
  - Assert reset_n=0 mid-DATA → all outputs 0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: parity modes, receiver state encoding, oversample
// ratio, and the parity-check helper used by the receiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_e;

  // True when the mode carries a parity bit (mode 3 behaves as none).
  function automatic logic has_parity(logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

  // Received parity bit vs. the bit implied by the XOR of the data bits.
  function automatic logic parity_mismatch(logic [1:0] mode, logic par_bit,
                                           logic data_xor);
    logic mismatch;
    case (mode)
      PAR_EVEN: mismatch = (par_bit != data_xor);
      PAR_ODD:  mismatch = (par_bit != ~data_xor);
      default:  mismatch = 1'b0;
    endcase
    return mismatch;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: mod-dvsr counter, one-cycle tick on the last
// count.
//   clk, reset_n : clock, async active-low reset
//   dvsr         : divisor in effect from the next cycle on (0 = no ticks)
//   load         : divisor is being updated; restart the count at 0
//   s_tick       : registered tick, high while counter == dvsr-1
module uart_baud_tick #(
  parameter int unsigned DVSR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              load,
  output logic              s_tick
);

  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic [DVSR_W-1:0] last_c;
  logic              tick_q, tick_d;

  // tick_q is precomputed from the next count so that it lines up with the
  // cycle in which cnt_q == dvsr-1.
  always_comb begin
    last_c = dvsr - DVSR_W'(1);
    cnt_d  = cnt_q + DVSR_W'(1);
    if (load || (dvsr == '0) || (cnt_q == last_c)) begin
      cnt_d = '0;
    end
    tick_d = (dvsr != '0) && (cnt_d == last_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign s_tick = tick_q;

endmodule

// File: rtl/uart_autoparity_rx.sv
// 16x-oversampling UART receiver configured by the autobaud/autoparity
// detector. Receives DBIT-bit frames with none/odd/even parity.
//   clk, reset_n   : clock, async active-low reset
//   rx             : asynchronous serial input, idle high
//   baud_dvsr      : clk cycles per oversample tick
//   parity_mode    : 0 none, 1 odd, 2 even, 3 none
//   cfg_load       : capture baud_dvsr/parity_mode (deferred while busy)
//   s_tick         : oversample tick
//   dout           : last received byte
//   rx_done_tick   : one-cycle pulse, dout and flags updated
//   parity_err     : parity mismatch on the last frame
//   frame_err      : stop bit sampled low on the last frame
//   cfg_ok         : a configuration has been loaded
module uart_autoparity_rx
  import uart_pkg::*;
#(
  parameter int unsigned DVSR_W  = 12,
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  input  logic [DVSR_W-1:0] baud_dvsr,
  input  logic [1:0]        parity_mode,
  input  logic              cfg_load,
  output logic              s_tick,
  output logic [DBIT-1:0]   dout,
  output logic              rx_done_tick,
  output logic              parity_err,
  output logic              frame_err,
  output logic              cfg_ok
);

  localparam logic [3:0] S_MID  = 4'((OVERSAMPLE / 2) - 1);
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] S_STOP = 4'(SB_TICK - 1);
  localparam logic [2:0] N_LAST = 3'(DBIT - 1);

  logic              rx_s1_q, rx_s2_q;
  logic              rx_sync;

  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic [1:0]        mode_q, mode_d;
  logic              cfg_ok_q, cfg_ok_d;
  logic              pend_q, pend_d;
  logic [DVSR_W-1:0] pend_dvsr_q, pend_dvsr_d;
  logic [1:0]        pend_mode_q, pend_mode_d;
  logic              load_c;

  rx_state_e         state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic [2:0]        n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic              p_q, p_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              done_q, done_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;

  assign rx_sync = rx_s2_q;

  // Config latch: immediate when idle, otherwise parked until the FSM idles.
  always_comb begin
    dvsr_d      = dvsr_q;
    mode_d      = mode_q;
    cfg_ok_d    = cfg_ok_q;
    pend_d      = pend_q;
    pend_dvsr_d = pend_dvsr_q;
    pend_mode_d = pend_mode_q;
    load_c      = 1'b0;
    if (cfg_load && (state_q == IDLE)) begin
      dvsr_d   = baud_dvsr;
      mode_d   = parity_mode;
      cfg_ok_d = 1'b1;
      pend_d   = 1'b0;
      load_c   = 1'b1;
    end else if (cfg_load) begin
      pend_d      = 1'b1;
      pend_dvsr_d = baud_dvsr;
      pend_mode_d = parity_mode;
    end else if (pend_q && (state_q == IDLE)) begin
      dvsr_d   = pend_dvsr_q;
      mode_d   = pend_mode_q;
      cfg_ok_d = 1'b1;
      pend_d   = 1'b0;
      load_c   = 1'b1;
    end
  end

  // Tick generator sees the divisor that will be live next cycle.
  uart_baud_tick #(
    .DVSR_W (DVSR_W)
  ) u_baud_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .dvsr    (dvsr_d),
    .load    (load_c),
    .s_tick  (s_tick)
  );

  // Receive FSM next-state and output logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    case (state_q)
      IDLE: begin
        if (cfg_ok_q && !rx_sync) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_sync) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            b_d = {rx_sync, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == N_LAST) begin
              state_d = has_parity(mode_q) ? PAR : STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            p_d     = rx_sync;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = ~rx_sync;
            perr_d  = parity_mismatch(mode_q, p_q, ^b_q);
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      dvsr_q      <= '0;
      mode_q      <= PAR_NONE;
      cfg_ok_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_dvsr_q <= '0;
      pend_mode_q <= PAR_NONE;
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      p_q         <= 1'b0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      dvsr_q      <= dvsr_d;
      mode_q      <= mode_d;
      cfg_ok_q    <= cfg_ok_d;
      pend_q      <= pend_d;
      pend_dvsr_q <= pend_dvsr_d;
      pend_mode_q <= pend_mode_d;
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      p_q         <= p_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign cfg_ok       = cfg_ok_q;

endmodule

// File: tb/tb_uart_autoparity_rx.sv
// Directed self-checking bench for uart_autoparity_rx.
module tb_uart_autoparity_rx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic [11:0] baud_dvsr = '0;
  logic [1:0]  parity_mode = '0;
  logic        cfg_load = 1'b0;
  logic        s_tick;
  logic [7:0]  dout;
  logic        rx_done_tick;
  logic        parity_err;
  logic        frame_err;
  logic        cfg_ok;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int tick_cnt = 0;

  uart_autoparity_rx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .baud_dvsr    (baud_dvsr),
    .parity_mode  (parity_mode),
    .cfg_load     (cfg_load),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .cfg_ok       (cfg_ok)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done_tick) done_cnt++;
    if (s_tick) tick_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [11:0] dv, input logic [1:0] m);
    @(negedge clk);
    baud_dvsr   = dv;
    parity_mode = m;
    cfg_load    = 1'b1;
    @(negedge clk);
    cfg_load    = 1'b0;
  endtask

  // Drives one frame; a bad stop bit is held low for 3/4 of a bit only.
  task automatic send_frame(input logic [7:0] d, input bit par_en,
                            input bit par_bit, input bit stop_ok,
                            input int dv);
    int bt;
    bt = 16 * dv;
    @(negedge clk);
    rx = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bt) @(negedge clk);
    end
    if (par_en) begin
      rx = par_bit;
      repeat (bt) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
    end else begin
      rx = 1'b0;
      repeat (12 * dv) @(negedge clk);
      rx = 1'b1;
    end
    repeat (2 * bt) @(negedge clk);
  endtask

  task automatic measure_period(output int per);
    int guard;
    guard = 0;
    per   = 0;
    @(negedge clk);
    while (!s_tick && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    per = 1;
    while (!s_tick && per < 2000) begin
      @(negedge clk);
      per++;
    end
  endtask

  task automatic expect_frame(input string tag, input int prev,
                              input logic [7:0] d, input bit pe,
                              input bit fe);
    check({tag, "_pulses"}, 32'(done_cnt - prev), 32'd1);
    check({tag, "_dout"}, 32'(dout), 32'(d));
    check({tag, "_perr"}, 32'(parity_err), 32'(pe));
    check({tag, "_ferr"}, 32'(frame_err), 32'(fe));
  endtask

  initial begin
    int prev;
    int t0;
    int per;

    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_done", 32'(rx_done_tick), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_cfg_ok", 32'(cfg_ok), 32'd0);
    check("rst_s_tick", 32'(s_tick), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Unconfigured: frame ignored, no ticks.
    prev = done_cnt;
    t0   = tick_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 27);
    check("uncfg_pulses", 32'(done_cnt - prev), 32'd0);
    check("uncfg_cfg_ok", 32'(cfg_ok), 32'd0);
    check("uncfg_ticks", 32'(tick_cnt - t0), 32'd0);

    // 8N1 at dvsr 27.
    cfg(12'd27, PAR_NONE);
    check("cfg_ok_set", 32'(cfg_ok), 32'd1);
    measure_period(per);
    check("tick_period_27", 32'(per), 32'd27);
    prev = done_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 27);
    expect_frame("n81_55", prev, 8'h55, 1'b0, 1'b0);

    // Even parity: 0x78 has four ones.
    cfg(12'd27, PAR_EVEN);
    prev = done_cnt;
    send_frame(8'h78, 1'b1, 1'b0, 1'b1, 27);
    expect_frame("even_ok", prev, 8'h78, 1'b0, 1'b0);
    prev = done_cnt;
    send_frame(8'h78, 1'b1, 1'b1, 1'b1, 27);
    expect_frame("even_bad", prev, 8'h78, 1'b1, 1'b0);

    // Odd parity: 0x31 has three ones, 0x33 four.
    cfg(12'd27, PAR_ODD);
    prev = done_cnt;
    send_frame(8'h31, 1'b1, 1'b0, 1'b1, 27);
    expect_frame("odd_ok", prev, 8'h31, 1'b0, 1'b0);
    prev = done_cnt;
    send_frame(8'h33, 1'b1, 1'b0, 1'b1, 27);
    expect_frame("odd_bad", prev, 8'h33, 1'b1, 1'b0);

    // Framing error then a clean frame.
    cfg(12'd27, PAR_NONE);
    prev = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 27);
    expect_frame("ferr_a5", prev, 8'hA5, 1'b0, 1'b1);
    prev = done_cnt;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 27);
    expect_frame("clean_0f", prev, 8'h0F, 1'b0, 1'b0);

    // Start-bit glitch: low for 3 ticks only.
    prev = done_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * 27) @(negedge clk);
    rx = 1'b1;
    repeat (20 * 27) @(negedge clk);
    check("glitch_pulses", 32'(done_cnt - prev), 32'd0);
    check("glitch_idle", 32'(dut.state_q), 32'(IDLE));

    // Reconfigure mid-frame: current frame finishes at 27, next at 54.
    prev = done_cnt;
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 27);
      begin
        repeat (16 * 27 * 4) @(negedge clk);
        cfg(12'd54, PAR_NONE);
      end
    join
    expect_frame("busy_cfg_c3", prev, 8'hC3, 1'b0, 1'b0);
    measure_period(per);
    check("tick_period_54", 32'(per), 32'd54);
    prev = done_cnt;
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 54);
    expect_frame("dvsr54_96", prev, 8'h96, 1'b0, 1'b0);

    // Asynchronous reset mid-DATA.
    cfg(12'd27, PAR_NONE);
    prev = done_cnt;
    fork
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 27);
      begin
        repeat (16 * 27 * 4) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_dout", 32'(dout), 32'd0);
        check("arst_done", 32'(rx_done_tick), 32'd0);
        check("arst_perr", 32'(parity_err), 32'd0);
        check("arst_ferr", 32'(frame_err), 32'd0);
        check("arst_cfg_ok", 32'(cfg_ok), 32'd0);
        check("arst_s_tick", 32'(s_tick), 32'd0);
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    check("arst_pulses", 32'(done_cnt - prev), 32'd0);
    check("arst_stay_idle", 32'(cfg_ok), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
